// File: rtl/mux_rr_nx1.sv
// Registered N-to-1 channel multiplexer with valid/ready handshakes.
// Selection is a fixed binary index or a fair round-robin scan.
module mux_rr_nx1 #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned CHANNELS = 16,
  localparam int unsigned SEL_W   = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
  output logic [CHANNELS-1:0]       in_ready,
  input  logic                      mode,
  input  logic [SEL_W-1:0]          sel,
  output logic [WIDTH-1:0]          out_data,
  output logic [SEL_W-1:0]          out_chan,
  output logic                      out_valid,
  input  logic                      out_ready
);

  localparam int unsigned         IDX_W     = SEL_W + 1;
  localparam logic [IDX_W-1:0]    CHAN_CNT  = IDX_W'(CHANNELS);
  localparam logic [SEL_W-1:0]    LAST_CHAN = SEL_W'(CHANNELS - 1);

  logic [WIDTH-1:0]    chan_data [CHANNELS];
  logic [SEL_W-1:0]    ptr;
  logic                load;
  logic                fix_any;
  logic                rr_any;
  logic [SEL_W-1:0]    rr_idx;
  logic [IDX_W-1:0]    rr_cand;
  logic                grant_any;
  logic [SEL_W-1:0]    grant_idx;
  logic [CHANNELS-1:0] grant_hit;
  logic [WIDTH-1:0]    grant_data;
  logic [SEL_W-1:0]    ptr_inc;

  for (genvar k = 0; k < CHANNELS; k++) begin : g_unpack
    assign chan_data[k] = in_data[k*WIDTH +: WIDTH];
  end

  // Fixed select matches sel against legal indices only, so out-of-range sel grants nothing.
  always_comb begin
    fix_any = 1'b0;
    for (int unsigned k = 0; k < CHANNELS; k++) begin
      if ((sel == SEL_W'(k)) && in_valid[k]) fix_any = 1'b1;
    end
  end

  // Round-robin: first valid channel at or after ptr, wrapping modulo CHANNELS.
  always_comb begin
    rr_any  = 1'b0;
    rr_idx  = '0;
    rr_cand = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      rr_cand = {1'b0, ptr} + IDX_W'(i);
      if (rr_cand >= CHAN_CNT) rr_cand = rr_cand - CHAN_CNT;
      if (!rr_any && in_valid[rr_cand[SEL_W-1:0]]) begin
        rr_any = 1'b1;
        rr_idx = rr_cand[SEL_W-1:0];
      end
    end
  end

  always_comb begin
    grant_any  = mode ? rr_any : fix_any;
    grant_idx  = mode ? rr_idx : sel;
    grant_hit  = '0;
    grant_data = '0;
    for (int unsigned k = 0; k < CHANNELS; k++) begin
      if (grant_any && (grant_idx == SEL_W'(k))) begin
        grant_hit[k] = 1'b1;
        grant_data   = chan_data[k];
      end
    end
  end

  assign load     = !out_valid || out_ready;
  // Held at zero during reset so no channel believes its word was taken.
  assign in_ready = (rst_n && load) ? grant_hit : '0;
  assign ptr_inc  = (grant_idx == LAST_CHAN) ? '0 : grant_idx + SEL_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_chan  <= '0;
      ptr       <= '0;
    end else if (load) begin
      if (grant_any) begin
        out_valid <= 1'b1;
        out_data  <= grant_data;
        out_chan  <= grant_idx;
        if (mode) ptr <= ptr_inc;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mux_rr_nx1.sv
// Bench for mux_rr_nx1: a 16-channel and a 6-channel instance against a queue-free
// behavioural model, plus directed literal checks of the select, wrap and reset behaviour.
module tb_mux_rr_nx1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // instance A: 16 channels
  logic [127:0] a_in_data;
  logic [15:0]  a_in_valid, a_in_ready;
  logic         a_mode, a_out_valid, a_out_ready;
  logic [3:0]   a_sel, a_out_chan;
  logic [7:0]   a_out_data;
  // instance B: 6 channels
  logic [47:0]  b_in_data;
  logic [5:0]   b_in_valid, b_in_ready;
  logic         b_mode, b_out_valid, b_out_ready;
  logic [2:0]   b_sel, b_out_chan;
  logic [7:0]   b_out_data;

  mux_rr_nx1 #(.WIDTH(8), .CHANNELS(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_data(a_in_data), .in_valid(a_in_valid),
    .in_ready(a_in_ready), .mode(a_mode), .sel(a_sel), .out_data(a_out_data),
    .out_chan(a_out_chan), .out_valid(a_out_valid), .out_ready(a_out_ready));

  mux_rr_nx1 #(.WIDTH(8), .CHANNELS(6)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_data(b_in_data), .in_valid(b_in_valid),
    .in_ready(b_in_ready), .mode(b_mode), .sel(b_sel), .out_data(b_out_data),
    .out_chan(b_out_chan), .out_valid(b_out_valid), .out_ready(b_out_ready));

  int n_cmp = 0;
  int n_bad = 0;
  int a_in_cnt = 0;
  int a_out_cnt = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model state per instance: what the output register must hold after the last edge.
  logic       m_valid [2];
  logic [7:0] m_data  [2];
  int         m_chan  [2];
  int         m_ptr   [2];

  task automatic model_cycle(input int inst, input int c, input logic [127:0] data,
                             input logic [15:0] valid, input logic mode, input int sel,
                             input logic ordy, input logic [15:0] rdy, input logic [7:0] odata,
                             input int ochan, input logic ovalid);
    int g;
    logic ld;
    logic [15:0] exp_rdy;
    string p;
    p = (inst == 0) ? "A" : "B";
    g = -1;
    exp_rdy = '0;
    ld = 1'b0;
    if (!rst_n) begin
      m_valid[inst] = 1'b0; m_data[inst] = '0; m_chan[inst] = 0; m_ptr[inst] = 0;
    end else begin
      if (!mode) begin
        if (sel < c && valid[sel]) g = sel;
      end else begin
        for (int j = 0; j < c; j++) begin
          if (g < 0 && valid[(m_ptr[inst] + j) % c]) g = (m_ptr[inst] + j) % c;
        end
      end
      ld = !m_valid[inst] || ordy;
      if (g >= 0 && ld) exp_rdy = 16'(1) << g;
    end
    chk({p, " in_ready"}, 64'(rdy), 64'(exp_rdy));
    chk({p, " out_valid"}, 64'(ovalid), 64'(m_valid[inst]));
    chk({p, " out_data"}, 64'(odata), 64'(m_data[inst]));
    chk({p, " out_chan"}, 64'(ochan), 64'(m_chan[inst]));
    if (rst_n && ld) begin
      if (g >= 0) begin
        m_valid[inst] = 1'b1;
        m_data[inst]  = data[g*8 +: 8];
        m_chan[inst]  = g;
        if (mode) m_ptr[inst] = (g + 1) % c;
      end else begin
        m_valid[inst] = 1'b0;
      end
    end
  endtask

  // Single compare process: inputs are stable from posedge+3 until the next posedge.
  always @(negedge clk) begin
    model_cycle(0, 16, a_in_data, a_in_valid, a_mode, int'(a_sel), a_out_ready, a_in_ready,
                a_out_data, int'(a_out_chan), a_out_valid);
    model_cycle(1, 6, 128'(b_in_data), 16'(b_in_valid), b_mode, int'(b_sel), b_out_ready,
                16'(b_in_ready), b_out_data, int'(b_out_chan), b_out_valid);
    if (!rst_n) begin
      a_in_cnt = 0; a_out_cnt = 0;
    end else begin
      if ((a_in_valid & a_in_ready) != 0) a_in_cnt++;
      if (a_out_valid && a_out_ready) a_out_cnt++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int exp_rr1 [5] = '{2, 7, 15, 2, 7};
  int exp_rr2 [4] = '{15, 2, 15, 2};

  initial begin
    a_mode = 1'b0; a_sel = 4'd5; a_in_valid = '1; a_out_ready = 1'b1;
    for (int k = 0; k < 16; k++) a_in_data[k*8 +: 8] = 8'(8'h10 + k);
    b_mode = 1'b1; b_sel = '0; b_in_valid = '1; b_out_ready = 1'b1;
    for (int k = 0; k < 6; k++) b_in_data[k*8 +: 8] = 8'(8'h20 + k);

    // reset state
    #1;
    chk("reset out_valid", 64'(a_out_valid), 64'd0);
    chk("reset in_ready", 64'(a_in_ready), 64'd0);
    step(); step();
    rst_n = 1'b1;
    #1;
    chk("fixed in_ready", 64'(a_in_ready), 64'h0020);

    // fixed select on A, round-robin wrap on B
    for (int i = 0; i < 7; i++) begin
      step();
      chk("fixed out_data", 64'(a_out_data), 64'h15);
      chk("fixed out_chan", 64'(a_out_chan), 64'd5);
      chk("fixed in_ready loop", 64'(a_in_ready), 64'h0020);
      chk("wrap6 out_chan", 64'(b_out_chan), 64'(i % 6));
    end

    // asynchronous reset clears out_valid without waiting for an edge
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("async reset out_valid", 64'(a_out_valid), 64'd0);
    step();
    rst_n = 1'b1;
    step(); step();

    // back-pressure
    a_out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("bp in_ready", 64'(a_in_ready), 64'd0);
      chk("bp out_data", 64'(a_out_data), 64'h15);
    end
    a_out_ready = 1'b1;
    #1;
    chk("bp release in_ready5", 64'(a_in_ready[5]), 64'd1);
    step(); step();
    chk("bp word count", 64'(a_in_cnt - a_out_cnt), 64'(a_out_valid));

    // round-robin fairness on channels 2, 7, 15
    a_mode = 1'b1; a_in_valid = 16'h8084;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("rr seq", 64'(a_out_chan), 64'(exp_rr1[i]));
    end
    a_in_valid = 16'h8004;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("rr seq drop7", 64'(a_out_chan), 64'(exp_rr2[i]));
    end

    // B: out-of-range fixed selects never grant
    b_mode = 1'b0; b_sel = 3'd6;
    #1;
    chk("sel6 in_ready", 64'(b_in_ready), 64'd0);
    step();
    chk("sel6 out_valid", 64'(b_out_valid), 64'd0);
    b_sel = 3'd7;
    #1;
    chk("sel7 in_ready", 64'(b_in_ready), 64'd0);
    step();
    chk("sel7 out_valid", 64'(b_out_valid), 64'd0);
    b_mode = 1'b1;

    // A: advance ptr to 9, detour through fixed mode, resume at 9
    a_in_valid = '1;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("rr to 9", 64'(a_out_chan), 64'(3 + i));
    end
    a_mode = 1'b0; a_sel = 4'd3;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("detour fixed3", 64'(a_out_chan), 64'd3);
    end
    a_mode = 1'b1;
    step();
    chk("resume ptr9", 64'(a_out_chan), 64'd9);

    // reset with a word pending: dropped, and ptr restarts at 0
    a_in_valid = 16'h0810;
    step();
    chk("pre-reset chan", 64'(a_out_chan), 64'd11);
    rst_n = 1'b0;
    #1;
    chk("mid reset out_valid", 64'(a_out_valid), 64'd0);
    step();
    rst_n = 1'b1;
    #1;
    chk("post reset no replay", 64'(a_out_valid), 64'd0);
    step();
    chk("post reset first grant", 64'(a_out_chan), 64'd4);

    // randomized traffic, checked by the negedge model
    for (int i = 0; i < 3000; i++) begin
      a_in_data   = {$urandom, $urandom, $urandom, $urandom};
      a_in_valid  = 16'($urandom) & 16'($urandom);
      a_mode      = 1'($urandom);
      a_sel       = 4'($urandom);
      a_out_ready = ($urandom_range(0, 3) != 0);
      b_in_data   = {16'($urandom), $urandom};
      b_in_valid  = 6'($urandom);
      b_mode      = 1'($urandom);
      b_sel       = 3'($urandom);
      b_out_ready = ($urandom_range(0, 3) != 0);
      if (i == 1500) rst_n = 1'b0;
      if (i == 1502) rst_n = 1'b1;
      step();
    end
    chk("final word count", 64'(a_in_cnt - a_out_cnt), 64'(a_out_valid));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
